serial_adder: RTL and testbench

Parametrised digit-serial adder/subtractor with a valid/ready handshake on both sides. It is the sequential successor to the gate-level half, full and 2-bit ripple adders: one DIGIT-bit ripple slice is reused over WIDTH/DIGIT cycles to add or subtract two WIDTH-bit operands. It sits between an operand source and a result sink in datapaths where area matters more than throughput.

---
 rtl/serial_adder.sv | 157 +++++++++++++++
 tb/tb_serial_adder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor with valid/ready handshakes.
// One DIGIT-bit ripple slice is reused over WIDTH/DIGIT cycles, LSB digit first.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; operands sampled only in IDLE
//   a, b                  WIDTH-bit operands
//   cin                   carry-in (add mode only)
//   sub                   0: a + b + cin, 1: a - b (a + ~b + 1)
//   out_valid / out_ready result handshake; result held until accepted
//   sum                   WIDTH-bit result, modulo 2^WIDTH
//   cout                  carry out of the MSB (sub mode: 1 = no borrow)
//   ovf                   two's-complement overflow
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              live_q, live_d;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_c;
  logic                   dig_cmsb;
  logic [WIDTH-1:0]       acc_next;
  logic                   last;

  // Ripple slice over the low digit of the shifting operand registers.
  always_comb begin
    logic [DIGIT-1:0]       da;
    logic [DIGIT-1:0]       db;
    logic [WIDTH+DIGIT-1:0] cat;
    logic                   c;
    da       = a_q[DIGIT-1:0];
    db       = b_q[DIGIT-1:0];
    c        = carry_q;
    dig_cmsb = carry_q;
    dig_s    = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dig_cmsb = c;
      dig_s[i] = da[i] ^ db[i] ^ c;
      c        = (da[i] & db[i]) | (c & (da[i] ^ db[i]));
    end
    dig_c = c;
    // Digits enter at the top and shift down; after N digits digit k sits at
    // [k*DIGIT +: DIGIT], matching an indexed write without a variable index.
    cat      = {dig_s, acc_q} >> DIGIT;
    acc_next = cat[WIDTH-1:0];
  end

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    live_d    = 1'b1;
    in_ready  = live_q && (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid && live_q) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_next;
        carry_d = dig_c;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d   = acc_next;
          cout_d  = dig_c;
          ovf_d   = dig_cmsb ^ dig_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      live_q  <= live_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: directed vectors on an 8/2 instance plus a
// random add/sub sweep over four WIDTH/DIGIT configurations, scoreboard style.
module tb_serial_adder;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input string why);
    chk_cnt++;
    $display("FAIL %s: %s at %0t", name, why, $time);
  endtask

  // ---------------- directed instance (WIDTH=8, DIGIT=2) ----------------
  logic       rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;

  serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  exp_t m_q[$];
  logic m_busy = 1'b0;
  logic m_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_seen = 1'b0;
    end else begin
      if (m_busy) chk("m_in_ready_busy", 32'(in_ready), 0);
      if (out_valid) begin
        if (m_q.size() == 0) fail_now("m_unexpected_out", "out_valid with empty scoreboard");
        else begin
          if (!m_seen) begin
            m_seen = 1'b1;
            chk("m_latency", 32'(cyc - m_q[0].acc), 4);
          end
          chk("m_sum", 32'(sum), m_q[0].s);
          chk("m_cout", 32'(cout), 32'(m_q[0].co));
          chk("m_ovf", 32'(ovf), 32'(m_q[0].ov));
          if (out_ready) begin
            void'(m_q.pop_front());
            m_busy = 1'b0;
            m_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) m_busy = 1'b1;
    end
  end

  task automatic m_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                      input logic tsub, input logic [7:0] es, input logic eco,
                      input logic eov, output int waited);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb_v; cin = tcin; sub = tsub;
    waited = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (in_ready) break;
      if (waited > 50) begin
        fail_now("m_accept", "operands never accepted");
        in_valid = 1'b0;
        return;
      end
    end
    e = '{32'(es), eco, eov, cyc + 1};
    m_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cin = 1'($urandom_range(0, 1));
    a   = 8'($urandom);
    b   = 8'($urandom);
  endtask

  task automatic m_wait_idle(input string name);
    int k;
    k = 0;
    while (m_q.size() != 0 && k < 60) begin
      @(negedge clk);
      if (cin === 1'b0 || cin === 1'b1) cin = 1'($urandom_range(0, 1));
      k++;
    end
    if (m_q.size() != 0) fail_now(name, "result never delivered");
  endtask

  // ---------------- parameter sweep ----------------
  logic sw_rst_n;

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W  = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 16 : 32;
    localparam int D  = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 4 : 2;
    localparam int N  = W / D;
    localparam int W1 = W + 1;

    logic         iv, ir, ci, sb, ovd, orr, co, ov;
    logic [W-1:0] ta, tbv, s;
    logic         done = 1'b0;
    logic         seen = 1'b0;
    exp_t         q[$];

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(sw_rst_n), .in_valid(iv), .in_ready(ir),
      .a(ta), .b(tbv), .cin(ci), .sub(sb), .out_valid(ovd),
      .out_ready(orr), .sum(s), .cout(co), .ovf(ov)
    );

    initial begin
      orr = 1'b1;
      forever begin
        @(posedge clk); #1;
        orr = ($urandom_range(0, 3) != 0);
      end
    end

    always @(negedge clk) begin
      if (sw_rst_n && ovd) begin
        if (q.size() == 0) fail_now("sw_unexpected_out", "out_valid with empty scoreboard");
        else begin
          if (!seen) begin
            seen = 1'b1;
            chk("sw_latency", 32'(cyc - q[0].acc), 32'(N));
          end
          if (orr) begin
            chk("sw_sum", 32'(s), q[0].s);
            chk("sw_cout", 32'(co), 32'(q[0].co));
            chk("sw_ovf", 32'(ov), 32'(q[0].ov));
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end

    initial begin
      logic [W-1:0] ra, rb, es;
      logic [W:0]   full;
      logic         rc, rs, eco, eov;
      int           k;
      exp_t         e;
      iv = 1'b0; ta = '0; tbv = '0; ci = 1'b0; sb = 1'b0;
      wait (sw_rst_n === 1'b1);
      for (int n = 0; n < 1000; n++) begin
        @(posedge clk); #1;
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        if (rs) full = {1'b0, ra} + {1'b0, ~rb} + W1'(1);
        else    full = {1'b0, ra} + {1'b0, rb} + W1'(rc);
        es  = full[W-1:0];
        eco = full[W];
        if (rs) eov = (ra[W-1] != rb[W-1]) && (es[W-1] != ra[W-1]);
        else    eov = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
        iv = 1'b1; ta = ra; tbv = rb; ci = rc; sb = rs;
        k = 0;
        while (1) begin
          @(negedge clk);
          k++;
          if (ir) break;
          if (k > 100) break;
        end
        if (!ir) begin
          fail_now("sw_accept", "operands never accepted");
          break;
        end
        e = '{32'(es), eco, eov, cyc + 1};
        q.push_back(e);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
          iv = 1'b0;
        end
      end
      @(posedge clk); #1;
      iv = 1'b0;
      k = 0;
      while (q.size() != 0 && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (q.size() != 0) fail_now("sw_drain", "results never delivered");
      done = 1'b1;
    end
  end

  initial begin
    sw_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 sw_rst_n = 1'b1;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int k;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_sum", 32'(sum), 0);
    chk("reset_cout", 32'(cout), 0);
    chk("reset_ovf", 32'(ovf), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_before_first_edge", 32'(in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_first_edge", 32'(in_ready), 1);

    m_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, w);
    m_wait_idle("add_5a_3c");
    m_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, w);
    m_wait_idle("add_ff_00_c1");
    m_op(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, w);
    m_wait_idle("add_7f_00_c1");
    m_op(8'h10, 8'h20, 1'($urandom_range(0, 1)), 1'b1, 8'hF0, 1'b0, 1'b0, w);
    m_wait_idle("sub_10_20");
    m_op(8'h80, 8'h01, 1'($urandom_range(0, 1)), 1'b1, 8'h7F, 1'b1, 1'b1, w);
    m_wait_idle("sub_80_01");

    // Backpressure with pending operands.
    out_ready = 1'b0;
    m_op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, w);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) fail_now("bp_out_valid", "out_valid never rose");
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    m_op(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, w);
    chk("bp_accept_after_handshake", 32'(w), 1);
    m_wait_idle("bp_pending_add");

    // Reset mid-RUN.
    m_op(8'h0F, 8'h0F, 1'b0, 1'b0, 8'h1E, 1'b0, 1'b0, w);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    chk("midrun_rst_sum", 32'(sum), 0);
    chk("midrun_rst_cout", 32'(cout), 0);
    chk("midrun_rst_ovf", 32'(ovf), 0);
    chk("midrun_rst_out_valid", 32'(out_valid), 0);
    chk("midrun_rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("in_reset_in_ready", 32'(in_ready), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_in_ready_before_edge", 32'(in_ready), 0);
    @(negedge clk);
    chk("rerelease_in_ready_after_edge", 32'(in_ready), 1);
    m_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, w);
    m_wait_idle("post_reset_add");

    k = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && k < 60000) begin
      @(negedge clk);
      k++;
    end
    if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done))
      fail_now("sweep_finish", "sweep did not complete");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
